// File: rtl/hex_updown_counter.sv
// hex_updown_counter: up/down counter with modulus, prescaler, parallel
// load, wrap/saturate boundary mode, terminal-count pulse, and registered
// active-low seven-segment hex outputs (one digit per count nibble).
// There is no FSM and no valid/ready handshake. Every output is a register.
module hex_updown_counter #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
    parameter bit               SATURATE  = 1'b0,
    parameter int               DIV       = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       up,
    input  logic                       load,
    input  logic [WIDTH-1:0]           load_value,
    output logic [WIDTH-1:0]           count,
    output logic                       tc,
    output logic [7*(WIDTH/4)-1:0]     hex
);

    localparam int             D      = WIDTH / 4;
    localparam int             PW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  P_LAST = PW'(DIV - 1);

    logic [PW-1:0]    presc;
    logic             step;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] step_count;
    logic             step_tc;
    logic [7*D-1:0]   hex_next;

    // Active-low segment pattern for one nibble, bits ordered g..a.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    // A full-range modulus needs no clamp; skipping it also avoids an
    // always-false compare when MAX_COUNT is all ones.
    generate
        if (MAX_COUNT == {WIDTH{1'b1}}) begin : g_no_clamp
            assign load_clamped = load_value;
        end else begin : g_clamp
            assign load_clamped = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
        end
    endgenerate

    // Next count for a step cycle, including boundary wrap/hold and tc.
    always_comb begin
        step       = enable && (presc == P_LAST);
        step_count = count;
        step_tc    = 1'b0;
        if (up) begin
            if (count == MAX_COUNT) begin
                step_tc    = 1'b1;
                step_count = SATURATE ? MAX_COUNT : '0;
            end else begin
                step_count = count + WIDTH'(1);
            end
        end else begin
            if (count == '0) begin
                step_tc    = 1'b1;
                step_count = SATURATE ? '0 : MAX_COUNT;
            end else begin
                step_count = count - WIDTH'(1);
            end
        end
    end

    // Segment image of the current count, one digit per nibble.
    always_comb begin
        hex_next = '0;
        for (int i = 0; i < D; i++) begin
            hex_next[7*i +: 7] = seg7(count[4*i +: 4]);
        end
    end

    // Prescaler: counts enabled cycles, cleared by reset and load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc <= '0;
        end else if (load) begin
            presc <= '0;
        end else if (enable) begin
            presc <= (presc == P_LAST) ? '0 : presc + PW'(1);
        end
    end

    // Count and terminal-count register; reset beats load beats step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            tc    <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            tc    <= 1'b0;
        end else if (step) begin
            count <= step_count;
            tc    <= step_tc;
        end else begin
            tc    <= 1'b0;
        end
    end

    // Display register: shows "0" straight out of reset, otherwise lags count by one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < D; i++) begin
                hex[7*i +: 7] <= 7'h40;
            end
        end else begin
            hex <= hex_next;
        end
    end

endmodule

// File: tb/tb_hex_updown_counter.sv
// Testbench for hex_updown_counter: four instances with different
// parameter sets, a scoreboard queue of {hex, tc, count} expectations,
// one task per scenario, and a final summary line.
module tb_hex_updown_counter;

    logic clk = 1'b0;
    logic rst_n;

    // Clock and reset
    always #5 clk = ~clk;

    // u_wrap: WIDTH=4, full range, wrap, DIV=1
    logic       a_en, a_up, a_load;
    logic [3:0] a_lv, a_count;
    logic       a_tc;
    logic [6:0] a_hex;
    // u_mod: WIDTH=8, MAX_COUNT=9, wrap, DIV=1
    logic        b_en, b_up, b_load;
    logic [7:0]  b_lv, b_count;
    logic        b_tc;
    logic [13:0] b_hex;
    // u_sat: WIDTH=4, full range, saturate, DIV=1
    logic       c_en, c_up, c_load;
    logic [3:0] c_lv, c_count;
    logic       c_tc;
    logic [6:0] c_hex;
    // u_pre: WIDTH=8, MAX_COUNT=100, wrap, DIV=3
    logic        d_en, d_up, d_load;
    logic [7:0]  d_lv, d_count;
    logic        d_tc;
    logic [13:0] d_hex;

    hex_updown_counter #(.WIDTH(4)) u_wrap (
        .clk(clk), .reset(rst_n), .enable(a_en), .up(a_up), .load(a_load),
        .load_value(a_lv), .count(a_count), .tc(a_tc), .hex(a_hex));

    hex_updown_counter #(.WIDTH(8), .MAX_COUNT(8'd9)) u_mod (
        .clk(clk), .reset(rst_n), .enable(b_en), .up(b_up), .load(b_load),
        .load_value(b_lv), .count(b_count), .tc(b_tc), .hex(b_hex));

    hex_updown_counter #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(rst_n), .enable(c_en), .up(c_up), .load(c_load),
        .load_value(c_lv), .count(c_count), .tc(c_tc), .hex(c_hex));

    hex_updown_counter #(.WIDTH(8), .MAX_COUNT(8'd100), .DIV(3)) u_pre (
        .clk(clk), .reset(rst_n), .enable(d_en), .up(d_up), .load(d_load),
        .load_value(d_lv), .count(d_count), .tc(d_tc), .hex(d_hex));

    // Scoreboard: {hex_hi[22:16], hex_lo[15:9], tc[8], count[7:0]}
    logic [22:0] exp_q[$];
    logic [22:0] want;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  a_prev, b_prev, c_prev, d_prev;

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] lut [16];
        lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return lut[n];
    endfunction

    // Expected display lags count by one cycle, so it is built from the
    // previously expected count.
    function automatic void push_exp(input logic tc_e, input logic [7:0] cnt,
                                     input logic [7:0] prev);
        exp_q.push_back({seg(prev[7:4]), seg(prev[3:0]), tc_e, cnt});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) push_exp(1'b0, 8'h00, 8'h00);
        tick();
        rst_n = 1'b1;
        want = exp_q.pop_front();
        n_cmp++; if (a_count !== want[3:0]) begin n_bad++; $display("FAIL reset_a_count got %0h want %0h", a_count, want[3:0]); end
        n_cmp++; if (a_tc !== want[8]) begin n_bad++; $display("FAIL reset_a_tc got %0b want %0b", a_tc, want[8]); end
        n_cmp++; if (a_hex !== want[15:9]) begin n_bad++; $display("FAIL reset_a_hex got %0h want %0h", a_hex, want[15:9]); end
        want = exp_q.pop_front();
        n_cmp++; if (b_count !== want[7:0]) begin n_bad++; $display("FAIL reset_b_count got %0h want %0h", b_count, want[7:0]); end
        n_cmp++; if (b_hex !== want[22:9]) begin n_bad++; $display("FAIL reset_b_hex got %0h want %0h", b_hex, want[22:9]); end
        want = exp_q.pop_front();
        n_cmp++; if (c_count !== want[3:0]) begin n_bad++; $display("FAIL reset_c_count got %0h want %0h", c_count, want[3:0]); end
        n_cmp++; if (c_hex !== want[15:9]) begin n_bad++; $display("FAIL reset_c_hex got %0h want %0h", c_hex, want[15:9]); end
        want = exp_q.pop_front();
        n_cmp++; if (d_count !== want[7:0]) begin n_bad++; $display("FAIL reset_d_count got %0h want %0h", d_count, want[7:0]); end
        n_cmp++; if (d_tc !== want[8]) begin n_bad++; $display("FAIL reset_d_tc got %0b want %0b", d_tc, want[8]); end
        n_cmp++; if (d_hex !== want[22:9]) begin n_bad++; $display("FAIL reset_d_hex got %0h want %0h", d_hex, want[22:9]); end
        a_prev = 8'h00; b_prev = 8'h00; c_prev = 8'h00; d_prev = 8'h00;
    endtask

    // 16 up-steps wrap F -> 0 with one tc, then one idle cycle.
    task automatic test_wrap();
        logic [7:0] cnt;
        a_en = 1'b1; a_up = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            if (i == 17) a_en = 1'b0;
            cnt = (i >= 16) ? 8'h00 : 8'(i);
            push_exp(i == 16, cnt, a_prev);
            a_prev = cnt;
            tick();
            want = exp_q.pop_front();
            n_cmp++; if (a_count !== want[3:0]) begin n_bad++; $display("FAIL wrap_count cyc %0d got %0h want %0h", i, a_count, want[3:0]); end
            n_cmp++; if (a_tc !== want[8]) begin n_bad++; $display("FAIL wrap_tc cyc %0d got %0b want %0b", i, a_tc, want[8]); end
            n_cmp++; if (a_hex !== want[15:9]) begin n_bad++; $display("FAIL wrap_hex cyc %0d got %0h want %0h", i, a_hex, want[15:9]); end
        end
    endtask

    // Down from 0 with MAX_COUNT=9: 9 (tc), 8, 7, 6, 5.
    task automatic test_down_modulus();
        logic [7:0] cnt;
        b_en = 1'b1; b_up = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cnt = 8'(9 - i);
            push_exp(i == 0, cnt, b_prev);
            b_prev = cnt;
            tick();
            want = exp_q.pop_front();
            n_cmp++; if (b_count !== want[7:0]) begin n_bad++; $display("FAIL down_count cyc %0d got %0h want %0h", i, b_count, want[7:0]); end
            n_cmp++; if (b_tc !== want[8]) begin n_bad++; $display("FAIL down_tc cyc %0d got %0b want %0b", i, b_tc, want[8]); end
            n_cmp++; if (b_hex !== want[22:9]) begin n_bad++; $display("FAIL down_hex cyc %0d got %0h want %0h", i, b_hex, want[22:9]); end
        end
        b_en = 1'b0;
    endtask

    // Clamp load 200 -> 9, load 5, then up,up,down,down,down.
    task automatic test_direction();
        int ld_t [7]  = '{1, 1, 0, 0, 0, 0, 0};
        int lv_t [7]  = '{200, 5, 0, 0, 0, 0, 0};
        int up_t [7]  = '{0, 0, 1, 1, 0, 0, 0};
        int cnt_t [7] = '{9, 5, 6, 7, 6, 5, 4};
        for (int i = 0; i < 7; i++) begin
            b_load = (ld_t[i] != 0); b_lv = 8'(lv_t[i]);
            b_up = (up_t[i] != 0); b_en = (ld_t[i] == 0);
            push_exp(1'b0, 8'(cnt_t[i]), b_prev);
            b_prev = 8'(cnt_t[i]);
            tick();
            want = exp_q.pop_front();
            n_cmp++; if (b_count !== want[7:0]) begin n_bad++; $display("FAIL dir_count cyc %0d got %0h want %0h", i, b_count, want[7:0]); end
            n_cmp++; if (b_tc !== want[8]) begin n_bad++; $display("FAIL dir_tc cyc %0d got %0b want %0b", i, b_tc, want[8]); end
            n_cmp++; if (b_hex !== want[22:9]) begin n_bad++; $display("FAIL dir_hex cyc %0d got %0h want %0h", i, b_hex, want[22:9]); end
        end
        b_load = 1'b0; b_en = 1'b0;
    endtask

    // Saturate at F going up and at 0 going down; tc on each blocked step.
    task automatic test_saturate();
        int en_t [10]  = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 0};
        int up_t [10]  = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        int ld_t [10]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        int lv_t [10]  = '{14, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        int cnt_t [10] = '{14, 15, 15, 15, 15, 1, 0, 0, 0, 0};
        int tc_t [10]  = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
        for (int i = 0; i < 10; i++) begin
            c_en = (en_t[i] != 0); c_up = (up_t[i] != 0);
            c_load = (ld_t[i] != 0); c_lv = 4'(lv_t[i]);
            push_exp(tc_t[i] != 0, 8'(cnt_t[i]), c_prev);
            c_prev = 8'(cnt_t[i]);
            tick();
            want = exp_q.pop_front();
            n_cmp++; if (c_count !== want[3:0]) begin n_bad++; $display("FAIL sat_count cyc %0d got %0h want %0h", i, c_count, want[3:0]); end
            n_cmp++; if (c_tc !== want[8]) begin n_bad++; $display("FAIL sat_tc cyc %0d got %0b want %0b", i, c_tc, want[8]); end
            n_cmp++; if (c_hex !== want[15:9]) begin n_bad++; $display("FAIL sat_hex cyc %0d got %0h want %0h", i, c_hex, want[15:9]); end
        end
        c_en = 1'b0; c_load = 1'b0;
    endtask

    // DIV=3: enable gating, load mid-prescale, clamp 200 -> 100, wrap at
    // 100 with tc, load beating a boundary step cycle.
    task automatic test_prescaler();
        int en_t [23]  = '{1,1,0,0,0,0,0,1, 1,1,1,1,1, 0,1,1,1,1,1,1, 1,1,1};
        int up_t [23]  = '{1,1,1,1,1,1,1,1, 1,1,1,1,1, 1,1,1,1,0,0,0, 1,1,1};
        int ld_t [23]  = '{0,0,0,0,0,0,0,0, 0,1,0,0,0, 1,0,0,0,0,0,1, 0,0,0};
        int lv_t [23]  = '{0,0,0,0,0,0,0,0, 0,10,0,0,0, 200,0,0,0,0,0,50, 0,0,0};
        int cnt_t [23] = '{0,0,0,0,0,0,0,1, 1,10,10,10,11, 100,100,100,0,0,0,50, 50,50,51};
        int tc_t [23]  = '{0,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,1,0,0,0, 0,0,0};
        for (int i = 0; i < 23; i++) begin
            d_en = (en_t[i] != 0); d_up = (up_t[i] != 0);
            d_load = (ld_t[i] != 0); d_lv = 8'(lv_t[i]);
            push_exp(tc_t[i] != 0, 8'(cnt_t[i]), d_prev);
            d_prev = 8'(cnt_t[i]);
            tick();
            want = exp_q.pop_front();
            n_cmp++; if (d_count !== want[7:0]) begin n_bad++; $display("FAIL pre_count cyc %0d got %0h want %0h", i, d_count, want[7:0]); end
            n_cmp++; if (d_tc !== want[8]) begin n_bad++; $display("FAIL pre_tc cyc %0d got %0b want %0b", i, d_tc, want[8]); end
            n_cmp++; if (d_hex !== want[22:9]) begin n_bad++; $display("FAIL pre_hex cyc %0d got %0h want %0h", i, d_hex, want[22:9]); end
        end
        d_en = 1'b0; d_load = 1'b0;
    endtask

    // Reset and load at the same edge: reset wins.
    task automatic test_reset_load();
        rst_n = 1'b0; d_load = 1'b1; d_lv = 8'd77;
        push_exp(1'b0, 8'h00, 8'h00);
        tick();
        rst_n = 1'b1; d_load = 1'b0;
        want = exp_q.pop_front();
        n_cmp++; if (d_count !== want[7:0]) begin n_bad++; $display("FAIL rstld_count got %0h want %0h", d_count, want[7:0]); end
        n_cmp++; if (d_tc !== want[8]) begin n_bad++; $display("FAIL rstld_tc got %0b want %0b", d_tc, want[8]); end
        n_cmp++; if (d_hex !== want[22:9]) begin n_bad++; $display("FAIL rstld_hex got %0h want %0h", d_hex, want[22:9]); end
    endtask

    // Sequence and final report
    initial begin
        rst_n = 1'b1;
        a_en = 1'b0; a_up = 1'b1; a_load = 1'b0; a_lv = '0;
        b_en = 1'b0; b_up = 1'b1; b_load = 1'b0; b_lv = '0;
        c_en = 1'b0; c_up = 1'b1; c_load = 1'b0; c_lv = '0;
        d_en = 1'b0; d_up = 1'b1; d_load = 1'b0; d_lv = '0;
        a_prev = '0; b_prev = '0; c_prev = '0; d_prev = '0;
        tick();
        test_reset();
        test_wrap();
        test_down_modulus();
        test_direction();
        test_saturate();
        test_prescaler();
        test_reset_load();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hex_updown_counter.md
# hex_updown_counter

Parametrised up/down counter with programmable modulus, prescaler, parallel load, wrap or saturate mode, and a terminal-count pulse. It drives WIDTH/4 active-low seven-segment digits with the hexadecimal value of the count. It is the general counter-plus-display block for board labs: KEY/SW-level controls go in, and HEX digit buses come out.

## Interface
- WIDTH, 16: count width in bits. Must be a multiple of 4, range 4..32. Digit count D = WIDTH/4.
- MAX_COUNT, 2**WIDTH-1: highest legal count. Must satisfy 0 < MAX_COUNT ≤ 2**WIDTH-1.
- SATURATE, 0: boundary behaviour. 0 = wrap at the boundary, 1 = hold at the boundary.
- DIV, 1: enabled clock cycles per count step. Must be ≥ 1.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  count enable; gates the prescaler and stepping.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled on each step cycle.
- load  in  1  parallel load strobe.
- load_value  in  WIDTH  value loaded when load=1.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered, one cycle wide.
- hex  out  7*D  segment buses. Digit i is hex[7i+6:7i] and shows count nibble i. Bit order within a digit is g..a, so bit 6 = g. Active-low.

## Operation
- Priority per edge: reset, then load, then step.
- Reset (reset=0 at an edge):
  - count=0, prescaler=0, tc=0.
  - every hex digit = 7'h40 (shows "0").
- Load (load=1):
  - count = min(load_value, MAX_COUNT).
  - prescaler cleared to 0; tc=0.
  - load ignores enable.
- Prescaler:
  - Internal counter p runs 0..DIV-1 and advances only when enable=1 and load=0.
  - A step cycle occurs when enable=1 and p==DIV-1; p then returns to 0.
  - With enable=0, p holds its value.
  - With DIV=1, every enabled cycle is a step cycle.
- Step, up=1:
  - count<MAX_COUNT → count+1.
  - count==MAX_COUNT → 0 (SATURATE=0) or hold (SATURATE=1), and tc asserts next cycle.
- Step, up=0:
  - count>0 → count-1.
  - count==0 → MAX_COUNT (SATURATE=0) or hold (SATURATE=1), and tc asserts next cycle.
- In saturate mode, every attempted step past the boundary produces a tc pulse.
- Count values above MAX_COUNT are unreachable, because load clamps them.
- Hex decode, active-low hex of each 4-bit nibble of count:
  - 0:40, 1:79, 2:24, 3:30
  - 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03
  - C:46, d:21, E:06, F:0E
- Flipping up between steps is legal. The new direction takes effect on the next step cycle.

## Timing
- count updates on the edge of the step or load cycle: latency 1 cycle from the qualifying inputs.
- tc is high for exactly the one cycle after the boundary step edge, i.e. coincident with the wrapped or held count. It is never high for two consecutive cycles when DIV>1.
- hex is registered from count, so it lags count by exactly 1 cycle. After reset it shows 0 immediately.
- load and reset asserted at the same edge: reset wins.
- load and a step cycle at the same edge: load wins, and no tc is produced.
- Reset or load mid-prescale discards the partial prescale; the first step follows DIV enabled cycles later.
- No combinational path from inputs to outputs.

## Test plan
- Reset then wrap:
  - Setup: WIDTH=4, DIV=1, SATURATE=0, enable=1, up=1, 16 clocks.
  - Required: count runs 0..F then 0; tc high only in the cycle count=0 after F; hex0 follows 40,79,...,0E,40 one cycle late.
- Down wrap with modulus:
  - Setup: WIDTH=8, MAX_COUNT=9, up=0, start from reset.
  - Required: first step gives count=9 with tc=1; then 8,7,...; hex = {hex1=40, hex0=10} one cycle after count=9.
- Saturate:
  - Setup: WIDTH=4, SATURATE=1, load 4'hE, up=1, 4 enabled steps.
  - Required: count E,F,F,F; tc pulses on the 2nd and 3rd steps only.
- Prescaler and enable gating:
  - Setup: DIV=3, enable high for 2 cycles, low for 5, high for 1.
  - Required: count steps 0→1 only at the 3rd enabled cycle.
  - Follow-up: load mid-prescale → next step is 3 enabled cycles after the load.
- Load clamp and priority:
  - Setup: MAX_COUNT=100, load_value=200 → count=100.
  - Required: load with a coincident step cycle → loaded value, tc=0; reset+load at the same edge → count=0.
- Direction change:
  - Setup: count=5, steps with up = 1,1,0,0,0.
  - Required: count 6,7,6,5,4, no tc.
